vta_mem_arbiter: RTL

- Parametrised N-channel front end for the single simulation memory port: req / write-beat / read-beat protocol, opcode 0 = read, 1 = write, burst of len+1 beats.
- Round-robin arbitrates among NUM_CH client channels.
- Locks the port to the winner for the whole burst.
- Routes write beats in and read beats back to the owning channel with backpressure.
- Sits between accelerator load/store units and the memory DPI bridge.

---
 rtl/vta_mem_arbiter_pkg.sv | 25 ++
 rtl/vta_mem_arbiter_rr.sv | 41 ++++
 rtl/vta_mem_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/vta_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// vta_mem_pkg : shared types and constants for the VTA memory-port front end
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vta_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // One extra bit so that len = 2^LEN_BITS-1 still counts len+1 beats.
  function automatic int beats_width(input int len_bits);
    return len_bits + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vta_mem_arbiter_rr.sv
// ----------------------------------------------------------------------------
// vta_rr_arbiter : combinational round-robin pick, first request at/after ptr
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vta_rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         i_req,
  input  logic [$clog2(NUM_CH)-1:0] i_ptr,
  output logic [NUM_CH-1:0]         o_grant,
  output logic [$clog2(NUM_CH)-1:0] o_grant_idx,
  output logic                      o_grant_valid
);

  localparam int IDX_W = $clog2(NUM_CH);

  logic [IDX_W:0] cand;

  always_comb begin
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    cand          = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, i_ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_CH)) begin
        cand = cand - (IDX_W+1)'(NUM_CH);
      end
      if (!o_grant_valid && i_req[cand[IDX_W-1:0]]) begin
        o_grant_valid                = 1'b1;
        o_grant_idx                  = cand[IDX_W-1:0];
        o_grant[cand[IDX_W-1:0]]     = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vta_mem_arbiter.sv
// ----------------------------------------------------------------------------
// vta_mem_arbiter : N-channel round-robin front end for the single memory port
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vta_mem_arbiter
  import vta_mem_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int LEN_BITS  = 8,
  parameter int ADDR_BITS = 64,
  parameter int DATA_BITS = 512
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           ch_req_valid,
  output logic [NUM_CH-1:0]           ch_req_ready,
  input  logic [NUM_CH-1:0]           ch_req_opcode,
  input  logic [NUM_CH*LEN_BITS-1:0]  ch_req_len,
  input  logic [NUM_CH*ADDR_BITS-1:0] ch_req_addr,
  input  logic [NUM_CH-1:0]           ch_wr_valid,
  output logic [NUM_CH-1:0]           ch_wr_ready,
  input  logic [NUM_CH*DATA_BITS-1:0] ch_wr_bits,
  output logic [NUM_CH-1:0]           ch_rd_valid,
  output logic [DATA_BITS-1:0]        ch_rd_bits,
  input  logic [NUM_CH-1:0]           ch_rd_ready,
  output logic                        mem_req_valid,
  output logic                        mem_req_opcode,
  output logic [LEN_BITS-1:0]         mem_req_len,
  output logic [ADDR_BITS-1:0]        mem_req_addr,
  output logic                        mem_wr_valid,
  output logic [DATA_BITS-1:0]        mem_wr_bits,
  input  logic                        mem_rd_valid,
  input  logic [DATA_BITS-1:0]        mem_rd_bits,
  output logic                        mem_rd_ready,
  output logic [$clog2(NUM_CH)-1:0]   owner,
  output logic                        busy,
  output logic                        err_spurious_rd
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int BL_W  = beats_width(LEN_BITS);

  state_e               state_q,          state_d;
  logic [IDX_W-1:0]     rr_ptr_q,         rr_ptr_d;
  logic [IDX_W-1:0]     owner_q,          owner_d;
  logic [BL_W-1:0]      beats_left_q,     beats_left_d;
  logic                 mem_req_valid_q,  mem_req_valid_d;
  logic                 mem_req_opcode_q, mem_req_opcode_d;
  logic [LEN_BITS-1:0]  mem_req_len_q,    mem_req_len_d;
  logic [ADDR_BITS-1:0] mem_req_addr_q,   mem_req_addr_d;
  logic                 mem_wr_valid_q,   mem_wr_valid_d;
  logic [DATA_BITS-1:0] mem_wr_bits_q,    mem_wr_bits_d;
  logic                 err_q,            err_d;

  logic [NUM_CH-1:0]    w_arb_grant;
  logic [IDX_W-1:0]     w_arb_idx;
  logic                 w_arb_valid;

  vta_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr_arbiter (
    .i_req         (ch_req_valid),
    .i_ptr         (rr_ptr_q),
    .o_grant       (w_arb_grant),
    .o_grant_idx   (w_arb_idx),
    .o_grant_valid (w_arb_valid)
  );

  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    owner_d          = owner_q;
    beats_left_d     = beats_left_q;
    mem_req_valid_d  = 1'b0;
    mem_req_opcode_d = mem_req_opcode_q;
    mem_req_len_d    = mem_req_len_q;
    mem_req_addr_d   = mem_req_addr_q;
    mem_wr_valid_d   = 1'b0;
    mem_wr_bits_d    = mem_wr_bits_q;
    err_d            = err_q;
    ch_req_ready     = '0;
    ch_wr_ready      = '0;
    ch_rd_valid      = '0;
    mem_rd_ready     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (w_arb_valid) begin
          ch_req_ready     = w_arb_grant;
          mem_req_valid_d  = 1'b1;
          mem_req_opcode_d = ch_req_opcode[w_arb_idx];
          mem_req_len_d    = ch_req_len[w_arb_idx*LEN_BITS +: LEN_BITS];
          mem_req_addr_d   = ch_req_addr[w_arb_idx*ADDR_BITS +: ADDR_BITS];
          beats_left_d     = {1'b0, ch_req_len[w_arb_idx*LEN_BITS +: LEN_BITS]} + BL_W'(1);
          owner_d          = w_arb_idx;
          rr_ptr_d         = (w_arb_idx == IDX_W'(NUM_CH-1)) ? '0 : w_arb_idx + IDX_W'(1);
          state_d          = (ch_req_opcode[w_arb_idx] == OP_RD) ? ST_READ : ST_WRITE;
        end
      end
      ST_WRITE: begin
        ch_wr_ready[owner_q] = 1'b1;
        if (ch_wr_valid[owner_q]) begin
          mem_wr_valid_d = 1'b1;
          mem_wr_bits_d  = ch_wr_bits[owner_q*DATA_BITS +: DATA_BITS];
          beats_left_d   = beats_left_q - BL_W'(1);
          if (beats_left_q == BL_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_READ: begin
        mem_rd_ready         = ch_rd_ready[owner_q];
        ch_rd_valid[owner_q] = mem_rd_valid;
        if (mem_rd_valid && ch_rd_ready[owner_q]) begin
          beats_left_d = beats_left_q - BL_W'(1);
          if (beats_left_q == BL_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A read beat with no read burst open has nowhere to go; drop and flag it.
    if (mem_rd_valid && (state_q != ST_READ)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      rr_ptr_q         <= '0;
      owner_q          <= '0;
      beats_left_q     <= '0;
      mem_req_valid_q  <= 1'b0;
      mem_req_opcode_q <= 1'b0;
      mem_req_len_q    <= '0;
      mem_req_addr_q   <= '0;
      mem_wr_valid_q   <= 1'b0;
      mem_wr_bits_q    <= '0;
      err_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      rr_ptr_q         <= rr_ptr_d;
      owner_q          <= owner_d;
      beats_left_q     <= beats_left_d;
      mem_req_valid_q  <= mem_req_valid_d;
      mem_req_opcode_q <= mem_req_opcode_d;
      mem_req_len_q    <= mem_req_len_d;
      mem_req_addr_q   <= mem_req_addr_d;
      mem_wr_valid_q   <= mem_wr_valid_d;
      mem_wr_bits_q    <= mem_wr_bits_d;
      err_q            <= err_d;
    end
  end

  assign ch_rd_bits      = mem_rd_bits;
  assign mem_req_valid   = mem_req_valid_q;
  assign mem_req_opcode  = mem_req_opcode_q;
  assign mem_req_len     = mem_req_len_q;
  assign mem_req_addr    = mem_req_addr_q;
  assign mem_wr_valid    = mem_wr_valid_q;
  assign mem_wr_bits     = mem_wr_bits_q;
  assign owner           = owner_q;
  assign busy            = (state_q != ST_IDLE);
  assign err_spurious_rd = err_q;

endmodule

`default_nettype wire
